imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive instruction-memory word addresses. It holds the core in reset until the whole image has been written, and optionally checksummed.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- reload  input  1  synchronous pulse; returns the loader to IDLE from any state.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; a byte transfers on a cycle with in_valid && in_ready.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  write data.
- core_reset  output  1  high whenever state != DONE; drives the core's counter reset.
- done  output  1  high in DONE.
- error  output  1  high in ERROR.

## Operation
- Frame format:
  - byte 0 is count[7:0] and byte 1 is count[15:8], the number of 32-bit words;
  - then 4*count data bytes, little-endian per word (first byte goes to bits 7:0);
  - then one checksum byte if LOADER_CHECKSUM_EN.
- States and transitions:
  - IDLE: accepts the count low byte, then goes to LEN_HI.
  - LEN_HI: accepts the count high byte.
    - count > 2^ADDR_WIDTH: go to ERROR.
    - count == 0: go to CHECK if the macro is defined, otherwise DONE.
    - otherwise: go to DATA.
  - DATA: accepts bytes into a 2-bit byte counter and a 24-bit shift register.
    - On the 4th byte of a word: the registered imem_we pulses the next cycle, with imem_addr equal to the word index and imem_wdata equal to the assembled word.
    - On the 4th byte of the last word: go to FLUSH.
  - FLUSH: one cycle, in_ready = 0. The final imem_we pulse occurs here. Then go to CHECK if the macro is defined, otherwise DONE.
  - CHECK: accepts one byte. Go to DONE if it equals the checksum, otherwise ERROR.
  - DONE: terminal; core_reset = 0.
  - ERROR: terminal; core_reset = 1.
- in_ready = 1 in IDLE, LEN_HI, DATA and CHECK; 0 in FLUSH, DONE and ERROR.
- Word index:
  - ADDR_WIDTH+1 bits wide, so count = 2^ADDR_WIDTH is legal;
  - imem_addr is its low ADDR_WIDTH bits;
  - it never wraps within a frame.
- Word counter: 16 bits; the final word is detected when the index equals count-1.
- reload:
  - Has priority over any byte transfer in the same cycle; that byte is dropped.
  - Clears counters and the checksum, goes to IDLE, and core_reset rises the next cycle.
  - Any imem_we pulse already scheduled for the next cycle is cancelled.
- Reset mid-frame: immediately returns to IDLE and discards the partial word. Nothing already written is rolled back.

## Timing
- Reset values:
  - state IDLE;
  - imem_we 0, imem_addr 0, imem_wdata 0;
  - core_reset 1, done 0, error 0;
  - in_ready 1, decoded from IDLE; no transfer happens while reset is high.
- Write latency: the 4th byte of a word transfers in cycle k; imem_we = 1 in cycle k+1 only.
- Without the macro:
  - the last data byte transfers in cycle k;
  - FLUSH with imem_we = 1 in cycle k+1;
  - done = 1 and core_reset = 0 from cycle k+2.
- With the macro: the checksum byte transfers in cycle m ≥ k+2; DONE or ERROR holds from cycle m+1.
- Back-to-back bytes are accepted every cycle in DATA; there is no stall between words.
- in_valid low in any state: no change.

## Configuration
- LOADER_CHECKSUM_EN:
  - Defined: the CHECK state exists, and an 8-bit running XOR of all data bytes (not the count bytes) is kept, cleared in IDLE. A mismatch leads to ERROR, and the core stays in reset.
  - Undefined: there is no CHECK state and no checksum register. FLUSH or LEN_HI (count == 0) goes directly to DONE, and error is asserted only on count overflow.

## Test plan
- Count 2, words 0x00500093 and 0x00A00113, streamed back-to-back -> imem_we pulses at addr 0 with 0x00500093, then at addr 1 with 0x00A00113; done rises 2 cycles after the last byte and core_reset falls with it.
- Count 0x0101 with ADDR_WIDTH = 8 -> ERROR the cycle after the count high byte; no imem_we pulses; core_reset stays 1.
- Count 256 with ADDR_WIDTH = 8 -> 256 writes at addresses 0..255 with no address wrap; DONE.
- Gaps on in_valid between bytes and a reload pulse after byte 2 of word 1 -> next frame is loaded from IDLE; word 0 of the new frame is written at addr 0.
- Reset asserted asynchronously mid-DATA -> all outputs take reset values immediately; a fresh frame then loads correctly.
- With LOADER_CHECKSUM_EN, count 1, word 0x11223344:
  - checksum byte 0x44 -> DONE;
  - checksum byte 0x45 -> ERROR, core_reset remains 1.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader bus bundle: byte stream in (valid/ready) and instruction-memory
// write port out. The loader uses the slave modport; the stream source / memory
// model side uses master.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Takes a framed byte stream
// (count lo, count hi, 4*count little-endian data bytes, optional checksum)
// and writes consecutive instruction-memory words, holding the core in reset
// until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// and the CHECK state; without it FLUSH / empty frames go straight to DONE.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         reload,
   imem_loader_if.slave bus,
   output logic         core_reset,
   output logic         done,
   output logic         error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      DATA,
      FLUSH,
`ifdef LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE,
      ERROR
   } state_t;

   // Largest legal word count is the full memory, so the compare needs 17 bits.
   localparam logic [16:0]         CAP     = 17'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

   state_t                state, state_n;
   logic [7:0]            len_lo;
   logic [15:0]           count;
   logic [ADDR_WIDTH:0]   widx;     // one extra bit so a full-memory frame never wraps
   logic [1:0]            bcnt;
   logic [23:0]           shreg;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum;
`endif

   logic        xfer;
   logic [15:0] len_full;
   logic        byte_last;
   logic        last_word;

   assign xfer      = bus.in_valid && bus.in_ready;
   assign len_full  = {bus.in_data, len_lo};
   assign byte_last = (bcnt == 2'd3);
   assign last_word = (16'(widx) == count - 16'd1);

   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;

   assign core_reset = (state != DONE);
   assign done       = (state == DONE);
   assign error      = (state == ERROR);

   // Stream is accepted only in the byte-consuming states.
   always_comb begin
      bus.in_ready = 1'b0;
      case (state)
         IDLE, LEN_HI, DATA:  bus.in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         CHECK:               bus.in_ready = 1'b1;
`endif
         default:             bus.in_ready = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state logic; reload overrides everything, including a same-cycle byte.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (xfer) state_n = LEN_HI;
         LEN_HI: if (xfer) begin
            if ({1'b0, len_full} > CAP) state_n = ERROR;
`ifdef LOADER_CHECKSUM_EN
            else if (len_full == 16'd0) state_n = CHECK;
`else
            else if (len_full == 16'd0) state_n = DONE;
`endif
            else                        state_n = DATA;
         end
         DATA:   if (xfer && byte_last && last_word) state_n = FLUSH;
`ifdef LOADER_CHECKSUM_EN
         FLUSH:  state_n = CHECK;
         CHECK:  if (xfer) state_n = (bus.in_data == csum) ? DONE : ERROR;
`else
         FLUSH:  state_n = DONE;
`endif
         default: ;
      endcase
      if (reload) state_n = IDLE;
   end

   // Datapath: length capture, word assembly, registered write strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_lo  <= '0;
         count   <= '0;
         widx    <= '0;
         bcnt    <= '0;
         shreg   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum    <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         if (reload) begin
            // Dropping we_q here cancels a write the 4th byte would have scheduled.
            len_lo <= '0;
            count  <= '0;
            widx   <= '0;
            bcnt   <= '0;
            shreg  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum   <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  widx <= '0;
                  bcnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                  csum <= '0;
`endif
                  if (xfer) len_lo <= bus.in_data;
               end
               LEN_HI: if (xfer) count <= len_full;
               DATA: if (xfer) begin
                  bcnt <= bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ bus.in_data;
`endif
                  if (byte_last) begin
                     we_q    <= 1'b1;
                     addr_q  <= widx[ADDR_WIDTH-1:0];
                     wdata_q <= {bus.in_data, shreg};
                     widx    <= widx + IDX_ONE;
                  end else begin
                     // First byte ends up in bits 7:0 after three shifts.
                     shreg <= {bus.in_data, shreg[23:8]};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Builds frames from random words, predicts
// the write sequence, write cycles and final status from the frame rules, and
// compares against a monitor of the write port.
module tb_imem_loader;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset, reload;
   logic core_reset, done, error;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .reload     (reload),
      .bus        (bus),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   logic [AW-1:0] mon_addr[$];
   logic [31:0]   mon_data[$];
   int            mon_cyc[$];
   logic [31:0]   frame_w[$];

   always @(negedge clk)
      if (bus.imem_we === 1'b1) begin
         mon_addr.push_back(bus.imem_addr);
         mon_data.push_back(bus.imem_wdata);
         mon_cyc.push_back(cyc);
      end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic mon_clear();
      mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   // Offers one byte (after an optional random idle gap); xc = cycle it transferred.
   task automatic send_byte(input logic [7:0] b, input int maxgap, output int xc);
      bit got = 0;
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      bus.in_data = b; bus.in_valid = 1'b1; xc = -1;
      for (int i = 0; i < 20 && !got; i++) begin
         if (bus.in_ready === 1'b1) begin got = 1; xc = cyc; end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL send_byte timeout: in_ready=%b want 1", bus.in_ready);
      end
   endtask

   // Streams a frame of frame_w[0..count-1] from IDLE and checks the outcome.
   task automatic run_frame(input int count, input bit bad, input int maxgap, input string nm);
      int xc, k, nexp;
      int exp_cyc[$];
      bit ovf, exp_done, exp_err;
      logic [7:0] cs = 8'h00;
      logic [7:0] b;
      ovf = (count > (1 << AW));
      nexp = ovf ? 0 : count;
      mon_clear();
      send_byte(count[7:0], maxgap, xc);
      send_byte(count[15:8], maxgap, xc);
      k = xc;
      if (!ovf)
         for (int i = 0; i < count; i++)
            for (int j = 0; j < 4; j++) begin
               b = frame_w[i][8*j +: 8];
               cs ^= b;
               send_byte(b, maxgap, xc);
               if (j == 3) exp_cyc.push_back(xc + 1);
               k = xc;
            end
`ifdef LOADER_CHECKSUM_EN
      exp_done = !ovf && !bad;
      exp_err  = ovf || bad;
      if (!ovf) send_byte(cs ^ {7'd0, bad}, 0, xc);
`else
      exp_done = !ovf;
      exp_err  = ovf || bad;
      if (!ovf && count > 0) begin
         n_chk++;
         if ({bus.imem_we, bus.in_ready, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s flush: we/ready/done=%b want 100", nm, {bus.imem_we, bus.in_ready, done});
         end
         @(negedge clk);
      end
`endif
      n_chk++;
      if ({done, error, core_reset} !== {exp_done, exp_err, !exp_done}) begin
         n_fail++;
         $display("FAIL %s status: done/error/core_reset=%b want %b", nm,
                  {done, error, core_reset}, {exp_done, exp_err, !exp_done});
      end
      n_chk++;
      if (mon_data.size() != nexp) begin
         n_fail++;
         $display("FAIL %s wcount: got %0d want %0d", nm, mon_data.size(), nexp);
      end
      for (int i = 0; i < nexp && i < mon_data.size(); i++) begin
         n_chk++;
         if (int'(mon_addr[i]) != i || mon_data[i] !== frame_w[i] || mon_cyc[i] != exp_cyc[i]) begin
            n_fail++;
            $display("FAIL %s wr%0d: addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                     nm, i, mon_addr[i], mon_data[i], mon_cyc[i], i, frame_w[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; reload = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
      @(negedge clk);
      bus.in_valid = 1'b1;   // must be ignored while reset is high
      @(negedge clk);
      n_chk++;
      if ({bus.in_ready, bus.imem_we, core_reset, done, error} !== 5'b10100 ||
          bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset: rdy/we/crst/done/err=%b addr=%h wdata=%h want 10100 0 0",
                  {bus.in_ready, bus.imem_we, core_reset, done, error}, bus.imem_addr, bus.imem_wdata);
      end
      bus.in_valid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      frame_w = '{32'h00500093, 32'h00A00113};
      run_frame(2, 0, 0, "basic");
   endtask

   task automatic test_overflow();
      do_reload();
      frame_w = '{};
      run_frame(16'h0101, 0, 0, "overflow");
      n_chk++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow ready: got %b want 0", bus.in_ready);
      end
   endtask

   task automatic test_zero();
      do_reload();
      frame_w = '{};
      run_frame(0, 0, 1, "zero");
   endtask

   task automatic test_gaps();
      do_reload();
      frame_w = '{};
      for (int i = 0; i < 5; i++) frame_w.push_back($urandom);
      run_frame(5, 0, 3, "gaps");
   endtask

   task automatic test_back_to_back();
      do_reload();
      frame_w = '{};
      for (int i = 0; i < 256; i++) frame_w.push_back($urandom);
      run_frame(256, 0, 0, "full256");
   endtask

   task automatic test_reload();
      int xc;
      logic [31:0] w0, w1;
      w0 = $urandom; w1 = $urandom;
      // From DONE: core_reset rises the cycle after the reload pulse.
      n_chk++;
      if (core_reset !== 1'b0) begin
         n_fail++; $display("FAIL reload pre: core_reset=%b want 0", core_reset);
      end
      do_reload();
      n_chk++;
      if ({core_reset, done, bus.in_ready} !== 3'b101) begin
         n_fail++; $display("FAIL reload from done: crst/done/rdy=%b want 101", {core_reset, done, bus.in_ready});
      end
      mon_clear();
      send_byte(8'd3, 2, xc); send_byte(8'd0, 2, xc);
      for (int j = 0; j < 4; j++) send_byte(w0[8*j +: 8], 2, xc);
      for (int j = 0; j < 2; j++) send_byte(w1[8*j +: 8], 2, xc);
      // Byte offered in the reload cycle must be dropped.
      bus.in_data = 8'hA5; bus.in_valid = 1'b1; reload = 1'b1;
      @(negedge clk);
      reload = 1'b0; bus.in_valid = 1'b0;
      n_chk++;
      if (mon_data.size() != 1 || mon_data[0] !== w0 || mon_addr[0] !== '0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reload mid: writes=%0d rdy=%b want 1 write of %h at 0, rdy 1",
                  mon_data.size(), bus.in_ready, w0);
      end
      frame_w = '{};
      for (int i = 0; i < 3; i++) frame_w.push_back($urandom);
      run_frame(3, 0, 1, "after_reload");
      // Reload alongside the 4th byte cancels the pending write.
      do_reload();
      mon_clear();
      send_byte(8'd1, 0, xc); send_byte(8'd0, 0, xc);
      for (int j = 0; j < 3; j++) send_byte(8'h10 + 8'(j), 0, xc);
      bus.in_data = 8'h77; bus.in_valid = 1'b1; reload = 1'b1;
      @(negedge clk);
      reload = 1'b0; bus.in_valid = 1'b0;
      n_chk++;
      if (bus.imem_we !== 1'b0 || mon_data.size() != 0) begin
         n_fail++;
         $display("FAIL reload cancel: we=%b writes=%0d want 0 0", bus.imem_we, mon_data.size());
      end
   endtask

   task automatic test_async_reset();
      int xc;
      do_reload();
      send_byte(8'd2, 0, xc); send_byte(8'd0, 0, xc);
      for (int j = 0; j < 4; j++) send_byte(8'($urandom), 0, xc);
      // Write strobe is high now; reset mid-cycle must clear it without a clock edge.
      #2 reset = 1'b1;
      #1;
      n_chk++;
      if ({bus.in_ready, bus.imem_we, core_reset, done, error} !== 5'b10100 ||
          bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL async reset: rdy/we/crst/done/err=%b addr=%h wdata=%h want 10100 0 0",
                  {bus.in_ready, bus.imem_we, core_reset, done, error}, bus.imem_addr, bus.imem_wdata);
      end
      @(negedge clk);
      reset = 1'b0;
      frame_w = '{};
      for (int i = 0; i < 2; i++) frame_w.push_back($urandom);
      run_frame(2, 0, 0, "after_reset");
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      frame_w = '{32'h11223344};
      do_reload();
      run_frame(1, 0, 0, "csum_ok");
      do_reload();
      run_frame(1, 1, 0, "csum_bad");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_zero();
      test_gaps();
      test_back_to_back();
      test_reload();
      test_async_reset();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
